ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage MIPS pipeline. It consumes the fields latched by the ID/EX register and resolves data hazards by forwarding from the EX/MEM and MEM/WB stages. It decodes ALUOp/funct, performs the ALU operation, computes the branch target and outcome, and latches everything the memory stage needs into an internal EX/MEM pipeline register with stall and flush control.

## Interface
- No parameters; datapath fixed at 32 bits, register index 5 bits.
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears the EX/MEM register
- stall  in  1  hold EX/MEM register contents
- flush  in  1  load a bubble: all control outputs 0
- RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch  in  1 each  control from ID/EX
- ALUOp  in  2  00 add, 01 sub, 10 R-type by funct, 11 add
- pc_in  in  32  PC+4 of the instruction in EX
- read_data1, read_data2  in  32  register-file operands rs, rt
- sign_ext_imm  in  32  sign-extended immediate; bits [10:6] are shamt, bits [5:0] are funct
- rs, rt, rd  in  5  register indices
- funct  in  6  R-type function code
- exmem_RegWrite_fwd  in  1  RegWrite of the instruction now in MEM (fed back from this block's outputs)
- exmem_rd_fwd  in  5  destination of the instruction in MEM
- exmem_alu_fwd  in  32  ALU result of the instruction in MEM
- memwb_RegWrite  in  1  RegWrite of the instruction in WB
- memwb_rd  in  5  destination of the instruction in WB
- memwb_data  in  32  final write-back value in WB
- MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out  out  1  registered control
- branch_taken_out  out  1  registered Branch & zero
- branch_target_out  out  32  registered pc_in + (sign_ext_imm << 2)
- alu_result_out  out  32  registered ALU result
- store_data_out  out  32  registered forwarded rt value
- write_reg_out  out  5  registered destination: rd if RegDst, else rt

## Operation
- Forward A (for rs), in priority order:
  - Use exmem_alu_fwd if exmem_RegWrite_fwd, exmem_rd_fwd≠0 and exmem_rd_fwd==rs.
  - Else use memwb_data if memwb_RegWrite, memwb_rd≠0 and memwb_rd==rs.
  - Else use read_data1.
- Forward B (for rt): same rules using rt and read_data2.
- The forwarded B value is store_data. The ALU B operand is sign_ext_imm if ALUSrc, else forwarded B.
- ALU control:
  - ALUOp 00 or 11: add. ALUOp 01: sub.
  - ALUOp 10, by funct: 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt, 000000 sll, 000010 srl. Any other funct: add.
- Shift rules: sll and srl shift forwarded B by sign_ext_imm[10:6]; srl is logical.
- slt compares signed and yields 32'd1 or 32'd0.
- add and sub wrap modulo 2^32; overflow is ignored and no trap is raised.
- zero = (ALU result == 0).
- Branch target = pc_in + {sign_ext_imm[29:0], 2'b00}, mod 2^32.
- EX/MEM register update priority, one action per clock: reset > flush > stall > load.
  - reset: all outputs 0.
  - flush: the four control outputs and branch_taken_out go to 0; data outputs load normally.
  - stall: every output holds.
  - load: outputs take the current computed values.
- Index 0 is never a forward source, even when RegWrite is high.

## Timing
- Combinational path: ID/EX fields → forward muxes → ALU → EX/MEM D inputs, within one cycle.
- Latency: 1 cycle. Values present at edge N appear on the outputs after edge N.
- Reset value of every output is 0, including targets and data.
- Reset asserted mid-stream clears the register at that edge, regardless of stall or flush.
- flush and stall both high in the same cycle: flush wins and a bubble is inserted.
- EX/MEM and MEM/WB both match a source: EX/MEM (younger) wins.
- The exmem_*_fwd inputs are driven externally from this block's outputs. There is no internal loop, so the block is testable standalone.

## Test plan
- Reset: hold reset 2 cycles with nonzero inputs → every output is 0. Assert stall together with reset → outputs still 0.
- R-type ALU and forwarding:
  - add: read_data1=5, read_data2=7, ALUOp=10, funct=100000, RegDst=1, rd=9 → alu_result_out=12, write_reg_out=9.
  - slt: -1 vs 1 → alu_result_out=1.
  - sll: 1 with shamt=4 → alu_result_out=16.
  - Forwarding priority: rs=3, exmem_rd_fwd=3 with value 100, memwb_rd=3 with value 200, both RegWrite=1 → operand A=100. Clear exmem_RegWrite_fwd → A=200. Set both rd to 0 → A=read_data1.
- Store forwarding: ALUSrc=1, MemWrite=1, imm=8, rt=4, memwb_rd=4, memwb_data=0xDEADBEEF → alu_result_out=rs+8, store_data_out=0xDEADBEEF.
- Branch: Branch=1, ALUOp=01, operands equal, pc_in=0x100, imm=0xFFFFFFFE → branch_taken_out=1, branch_target_out=0xF8. With unequal operands → branch_taken_out=0.
- Flush and stall:
  - stall=1 for 3 cycles with changing inputs → outputs frozen.
  - flush=1 while RegWrite=MemWrite=1 → all control outputs 0.
  - flush and stall both high → bubble inserted.

Source files
------------

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage of a 5-stage MIPS pipeline.
//
// Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages,
// decodes ALUOp/funct into an ALU operation, computes the branch target and
// outcome, and captures everything the memory stage needs in an internal
// EX/MEM register (synchronous reset, flush-to-bubble, stall-to-hold).
//
// Ports
//   clk, reset (sync, active-high), stall, flush  : pipeline control
//   RegDst, ALUSrc, MemToReg, RegWrite, MemRead,
//   MemWrite, Branch, ALUOp[1:0]                   : ID/EX control fields
//   pc_in, read_data1, read_data2, sign_ext_imm    : ID/EX data fields
//   rs, rt, rd, funct                              : ID/EX index/function fields
//   exmem_RegWrite_fwd, exmem_rd_fwd,
//   exmem_alu_fwd                                  : forwarding source in MEM
//   memwb_RegWrite, memwb_rd, memwb_data           : forwarding source in WB
//   *_out                                          : registered EX/MEM outputs
// ---------------------------------------------------------------------------
module ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        RegDst,
    input  logic        ALUSrc,
    input  logic        MemToReg,
    input  logic        RegWrite,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        Branch,
    input  logic [1:0]  ALUOp,
    input  logic [31:0] pc_in,
    input  logic [31:0] read_data1,
    input  logic [31:0] read_data2,
    input  logic [31:0] sign_ext_imm,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [5:0]  funct,
    input  logic        exmem_RegWrite_fwd,
    input  logic [4:0]  exmem_rd_fwd,
    input  logic [31:0] exmem_alu_fwd,
    input  logic        memwb_RegWrite,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_data,
    output logic        MemToReg_out,
    output logic        RegWrite_out,
    output logic        MemRead_out,
    output logic        MemWrite_out,
    output logic        branch_taken_out,
    output logic [31:0] branch_target_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] store_data_out,
    output logic [4:0]  write_reg_out
);

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_NOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_SLL = 6'b000000;
    localparam logic [5:0] FUNCT_SRL = 6'b000010;

    // Operand select: the younger EX/MEM result beats MEM/WB; register 0 is
    // hard-wired zero in the register file, so it is never a forward source.
    function automatic logic [31:0] forward_operand(
        input logic [4:0]  src_idx,
        input logic [31:0] rf_val,
        input logic        ex_we,
        input logic [4:0]  ex_rd,
        input logic [31:0] ex_val,
        input logic        wb_we,
        input logic [4:0]  wb_rd,
        input logic [31:0] wb_val
    );
        logic [31:0] sel;
        if (ex_we && (ex_rd != 5'd0) && (ex_rd == src_idx)) begin
            sel = ex_val;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src_idx)) begin
            sel = wb_val;
        end else begin
            sel = rf_val;
        end
        return sel;
    endfunction

    // Upper immediate bits fall off the word-aligned branch offset shift.
    logic unused_imm_hi_s;
    assign unused_imm_hi_s = ^sign_ext_imm[31:30];

    logic [31:0] fwd_a_s;
    logic [31:0] fwd_b_s;
    logic [31:0] alu_b_s;
    logic [4:0]  shamt_s;
    alu_op_e     alu_op_s;
    logic [31:0] alu_result_s;
    logic        zero_s;
    logic [31:0] branch_target_s;
    logic [4:0]  write_reg_s;

    logic        mem_to_reg_d,    mem_to_reg_q;
    logic        reg_write_d,     reg_write_q;
    logic        mem_read_d,      mem_read_q;
    logic        mem_write_d,     mem_write_q;
    logic        branch_taken_d,  branch_taken_q;
    logic [31:0] branch_target_d, branch_target_q;
    logic [31:0] alu_result_d,    alu_result_q;
    logic [31:0] store_data_d,    store_data_q;
    logic [4:0]  write_reg_d,     write_reg_q;

    // Forwarding muxes for both source operands and ALU B selection.
    always_comb begin
        fwd_a_s = forward_operand(rs, read_data1,
                                  exmem_RegWrite_fwd, exmem_rd_fwd, exmem_alu_fwd,
                                  memwb_RegWrite, memwb_rd, memwb_data);
        fwd_b_s = forward_operand(rt, read_data2,
                                  exmem_RegWrite_fwd, exmem_rd_fwd, exmem_alu_fwd,
                                  memwb_RegWrite, memwb_rd, memwb_data);
        if (ALUSrc) begin
            alu_b_s = sign_ext_imm;
        end else begin
            alu_b_s = fwd_b_s;
        end
        shamt_s = sign_ext_imm[10:6];
    end

    // ALU control decode: ALUOp picks add/sub directly, 10 defers to funct.
    always_comb begin
        alu_op_s = ALU_ADD;
        case (ALUOp)
            2'b00:   alu_op_s = ALU_ADD;
            2'b01:   alu_op_s = ALU_SUB;
            2'b10: begin
                case (funct)
                    FUNCT_ADD: alu_op_s = ALU_ADD;
                    FUNCT_SUB: alu_op_s = ALU_SUB;
                    FUNCT_AND: alu_op_s = ALU_AND;
                    FUNCT_OR:  alu_op_s = ALU_OR;
                    FUNCT_NOR: alu_op_s = ALU_NOR;
                    FUNCT_SLT: alu_op_s = ALU_SLT;
                    FUNCT_SLL: alu_op_s = ALU_SLL;
                    FUNCT_SRL: alu_op_s = ALU_SRL;
                    default:   alu_op_s = ALU_ADD;
                endcase
            end
            2'b11:   alu_op_s = ALU_ADD;
            default: alu_op_s = ALU_ADD;
        endcase
    end

    // ALU datapath; shifts always act on the forwarded rt value, not the
    // immediate, because shamt itself lives inside the immediate field.
    always_comb begin
        alu_result_s = 32'd0;
        case (alu_op_s)
            ALU_ADD: alu_result_s = fwd_a_s + alu_b_s;
            ALU_SUB: alu_result_s = fwd_a_s - alu_b_s;
            ALU_AND: alu_result_s = fwd_a_s & alu_b_s;
            ALU_OR:  alu_result_s = fwd_a_s | alu_b_s;
            ALU_NOR: alu_result_s = ~(fwd_a_s | alu_b_s);
            ALU_SLT: begin
                if ($signed(fwd_a_s) < $signed(alu_b_s)) begin
                    alu_result_s = 32'd1;
                end else begin
                    alu_result_s = 32'd0;
                end
            end
            ALU_SLL: alu_result_s = fwd_b_s << shamt_s;
            ALU_SRL: alu_result_s = fwd_b_s >> shamt_s;
            default: alu_result_s = fwd_a_s + alu_b_s;
        endcase
    end

    // Branch outcome/target and destination register select.
    always_comb begin
        zero_s          = (alu_result_s == 32'd0);
        branch_target_s = pc_in + {sign_ext_imm[29:0], 2'b00};
        if (RegDst) begin
            write_reg_s = rd;
        end else begin
            write_reg_s = rt;
        end
    end

    // EX/MEM next-state: flush beats stall beats load (reset handled in the flop).
    always_comb begin
        mem_to_reg_d    = mem_to_reg_q;
        reg_write_d     = reg_write_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        branch_taken_d  = branch_taken_q;
        branch_target_d = branch_target_q;
        alu_result_d    = alu_result_q;
        store_data_d    = store_data_q;
        write_reg_d     = write_reg_q;
        if (flush) begin
            // Bubble: kill every side effect but let the data fields flow.
            mem_to_reg_d    = 1'b0;
            reg_write_d     = 1'b0;
            mem_read_d      = 1'b0;
            mem_write_d     = 1'b0;
            branch_taken_d  = 1'b0;
            branch_target_d = branch_target_s;
            alu_result_d    = alu_result_s;
            store_data_d    = fwd_b_s;
            write_reg_d     = write_reg_s;
        end else if (stall) begin
            mem_to_reg_d    = mem_to_reg_q;
            reg_write_d     = reg_write_q;
            mem_read_d      = mem_read_q;
            mem_write_d     = mem_write_q;
            branch_taken_d  = branch_taken_q;
            branch_target_d = branch_target_q;
            alu_result_d    = alu_result_q;
            store_data_d    = store_data_q;
            write_reg_d     = write_reg_q;
        end else begin
            mem_to_reg_d    = MemToReg;
            reg_write_d     = RegWrite;
            mem_read_d      = MemRead;
            mem_write_d     = MemWrite;
            branch_taken_d  = Branch & zero_s;
            branch_target_d = branch_target_s;
            alu_result_d    = alu_result_s;
            store_data_d    = fwd_b_s;
            write_reg_d     = write_reg_s;
        end
    end

    // EX/MEM register with synchronous reset that overrides flush and stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_to_reg_q    <= 1'b0;
            reg_write_q     <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            branch_taken_q  <= 1'b0;
            branch_target_q <= 32'd0;
            alu_result_q    <= 32'd0;
            store_data_q    <= 32'd0;
            write_reg_q     <= 5'd0;
        end else begin
            mem_to_reg_q    <= mem_to_reg_d;
            reg_write_q     <= reg_write_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            branch_taken_q  <= branch_taken_d;
            branch_target_q <= branch_target_d;
            alu_result_q    <= alu_result_d;
            store_data_q    <= store_data_d;
            write_reg_q     <= write_reg_d;
        end
    end

    assign MemToReg_out      = mem_to_reg_q;
    assign RegWrite_out      = reg_write_q;
    assign MemRead_out       = mem_read_q;
    assign MemWrite_out      = mem_write_q;
    assign branch_taken_out  = branch_taken_q;
    assign branch_target_out = branch_target_q;
    assign alu_result_out    = alu_result_q;
    assign store_data_out    = store_data_q;
    assign write_reg_out     = write_reg_q;

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage -- self-checking bench for ex_stage: a table of directed
// vectors with hand-computed results, hand-written reset/stall/flush
// sequences, and randomized cycles checked against a behavioural model.
// ---------------------------------------------------------------------------
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch;
    logic [1:0]  ALUOp;
    logic [31:0] pc_in, read_data1, read_data2, sign_ext_imm;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic        exmem_RegWrite_fwd;
    logic [4:0]  exmem_rd_fwd;
    logic [31:0] exmem_alu_fwd;
    logic        memwb_RegWrite;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;
    logic        MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out, branch_taken_out;
    logic [31:0] branch_target_out, alu_result_out, store_data_out;
    logic [4:0]  write_reg_out;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .MemToReg(MemToReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp),
        .pc_in(pc_in), .read_data1(read_data1), .read_data2(read_data2),
        .sign_ext_imm(sign_ext_imm), .rs(rs), .rt(rt), .rd(rd), .funct(funct),
        .exmem_RegWrite_fwd(exmem_RegWrite_fwd), .exmem_rd_fwd(exmem_rd_fwd),
        .exmem_alu_fwd(exmem_alu_fwd), .memwb_RegWrite(memwb_RegWrite),
        .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .MemToReg_out(MemToReg_out), .RegWrite_out(RegWrite_out),
        .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
        .branch_taken_out(branch_taken_out), .branch_target_out(branch_target_out),
        .alu_result_out(alu_result_out), .store_data_out(store_data_out),
        .write_reg_out(write_reg_out)
    );

    typedef struct packed {
        logic        mtr, rw, mr, mw, bt;
        logic [31:0] target, alu, store;
        logic [4:0]  wreg;
    } outs_t;

    typedef struct {
        logic [1:0]  aluop;
        logic [5:0]  fn;
        logic        alusrc, regdst, branch, memwrite;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  vrs, vrt, vrd;
        logic        exw;
        logic [4:0]  exrd;
        logic [31:0] exv;
        logic        mww;
        logic [4:0]  mwrd;
        logic [31:0] mwv;
        logic [31:0] e_alu, e_store;
        logic [4:0]  e_wreg;
        logic        e_taken;
        logic [31:0] e_target;
    } vec_t;

    int    tests  = 0;
    int    failed = 0;
    outs_t exp_q;
    vec_t  vecs[16];

    function automatic outs_t dut_outs();
        return {MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out, branch_taken_out,
                branch_target_out, alu_result_out, store_data_out, write_reg_out};
    endfunction

    task automatic check(input string nm, input outs_t want);
        outs_t got;
        got = dut_outs();
        tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    task automatic check_bit(input string nm, input logic got, input logic want);
        tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s: got %b expected %b", nm, got, want);
        end
    endtask

    // ---- behavioural reference model ----
    function automatic logic [31:0] src_val(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 5'd0) return rf;
        if (exmem_RegWrite_fwd && exmem_rd_fwd == idx) return exmem_alu_fwd;
        if (memwb_RegWrite && memwb_rd == idx) return memwb_data;
        return rf;
    endfunction

    function automatic outs_t model_comb();
        outs_t       o;
        logic [31:0] a, bf, b, r;
        int          sh;
        a  = src_val(rs, read_data1);
        bf = src_val(rt, read_data2);
        b  = ALUSrc ? sign_ext_imm : bf;
        sh = int'(sign_ext_imm[10:6]);
        if (ALUOp == 2'b01)      r = a - b;
        else if (ALUOp != 2'b10) r = a + b;
        else begin
            case (funct)
                6'h22:   r = a - b;
                6'h24:   r = a & b;
                6'h25:   r = a | b;
                6'h27:   r = ~(a | b);
                6'h2A:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h00:   r = bf << sh;
                6'h02:   r = bf >> sh;
                default: r = a + b;
            endcase
        end
        o.alu    = r;
        o.store  = bf;
        o.wreg   = RegDst ? rd : rt;
        o.target = pc_in + sign_ext_imm * 32'd4;
        o.bt     = Branch && (r == 32'd0);
        o.mtr    = MemToReg;
        o.rw     = RegWrite;
        o.mr     = MemRead;
        o.mw     = MemWrite;
        return o;
    endfunction

    function automatic outs_t model_step(input outs_t cur);
        outs_t n;
        if (reset) n = '0;
        else if (flush) begin
            n = model_comb();
            n.mtr = 1'b0; n.rw = 1'b0; n.mr = 1'b0; n.mw = 1'b0; n.bt = 1'b0;
        end else if (stall) n = cur;
        else n = model_comb();
        return n;
    endfunction

    // One clock: predict, clock, then let outputs settle before sampling.
    task automatic cycle();
        outs_t nxt;
        nxt = model_step(exp_q);
        @(posedge clk);
        #1;
        exp_q = nxt;
    endtask

    task automatic randomize_inputs();
        RegDst = 1'($urandom); ALUSrc = 1'($urandom); MemToReg = 1'($urandom);
        RegWrite = 1'($urandom); MemRead = 1'($urandom); MemWrite = 1'($urandom);
        Branch = 1'($urandom); ALUOp = 2'($urandom);
        pc_in = $urandom; read_data1 = $urandom;
        read_data2 = ($urandom_range(0, 3) == 0) ? read_data1 : $urandom;
        sign_ext_imm = $urandom;
        rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom);
        case ($urandom_range(0, 8))
            0: funct = 6'h20; 1: funct = 6'h22; 2: funct = 6'h24; 3: funct = 6'h25;
            4: funct = 6'h27; 5: funct = 6'h2A; 6: funct = 6'h00; 7: funct = 6'h02;
            default: funct = 6'($urandom);
        endcase
        exmem_RegWrite_fwd = 1'($urandom); exmem_rd_fwd = 5'($urandom_range(0, 3));
        exmem_alu_fwd = $urandom;
        memwb_RegWrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3));
        memwb_data = $urandom;
    endtask

    task automatic apply_vec(input vec_t v);
        ALUOp = v.aluop; funct = v.fn; ALUSrc = v.alusrc; RegDst = v.regdst;
        Branch = v.branch; MemWrite = v.memwrite; RegWrite = 1'b1;
        MemToReg = 1'b0; MemRead = 1'b0;
        pc_in = v.pc; read_data1 = v.rd1; read_data2 = v.rd2; sign_ext_imm = v.imm;
        rs = v.vrs; rt = v.vrt; rd = v.vrd;
        exmem_RegWrite_fwd = v.exw; exmem_rd_fwd = v.exrd; exmem_alu_fwd = v.exv;
        memwb_RegWrite = v.mww; memwb_rd = v.mwrd; memwb_data = v.mwv;
    endtask

    initial begin
        outs_t saved;
        // aluop fn src dst br mw pc rd1 rd2 imm rs rt rd exw exrd exv mww mwrd mwv | alu store wreg taken target
        vecs[0]  = '{2'b10, 6'h20, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'd5, 32'd7, 32'h20, 5'd1, 5'd2, 5'd9,
                     1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd12, 32'd7, 5'd9, 1'b0, 32'h80};
        vecs[1]  = '{2'b10, 6'h2A, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h2A, 5'd1, 5'd2, 5'd10,
                     1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd1, 32'd1, 5'd10, 1'b0, 32'hA8};
        vecs[2]  = '{2'b10, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'd0, 32'd1, 32'h100, 5'd1, 5'd2, 5'd11,
                     1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd16, 32'd1, 5'd11, 1'b0, 32'h400};
        vecs[3]  = '{2'b00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'd50, 32'd0, 32'h0, 5'd3, 5'd5, 5'd0,
                     1'b1, 5'd3, 32'd100, 1'b1, 5'd3, 32'd200, 32'd100, 32'd0, 5'd5, 1'b0, 32'h10};
        vecs[4]  = '{2'b00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'd50, 32'd0, 32'h0, 5'd3, 5'd5, 5'd0,
                     1'b0, 5'd3, 32'd100, 1'b1, 5'd3, 32'd200, 32'd200, 32'd0, 5'd5, 1'b0, 32'h10};
        vecs[5]  = '{2'b00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'd50, 32'd0, 32'h0, 5'd3, 5'd5, 5'd0,
                     1'b1, 5'd0, 32'd100, 1'b1, 5'd0, 32'd200, 32'd50, 32'd0, 5'd5, 1'b0, 32'h10};
        vecs[6]  = '{2'b00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'd50, 32'd0, 32'h0, 5'd0, 5'd5, 5'd0,
                     1'b1, 5'd0, 32'd100, 1'b1, 5'd0, 32'd200, 32'd50, 32'd0, 5'd5, 1'b0, 32'h10};
        vecs[7]  = '{2'b00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h1000, 32'h11111111, 32'd8, 5'd6, 5'd4, 5'd0,
                     1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'hDEADBEEF, 32'h1008, 32'hDEADBEEF, 5'd4, 1'b0, 32'h20};
        vecs[8]  = '{2'b01, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h55, 32'h55, 32'hFFFFFFFE, 5'd1, 5'd7, 5'd0,
                     1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'h55, 5'd7, 1'b1, 32'hF8};
        vecs[9]  = '{2'b01, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h55, 32'h54, 32'hFFFFFFFE, 5'd1, 5'd7, 5'd0,
                     1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd1, 32'h54, 5'd7, 1'b0, 32'hF8};
        vecs[10] = '{2'b01, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd10, 32'd0, 32'h0, 5'd1, 5'd8, 5'd0,
                     1'b1, 5'd8, 32'd3, 1'b1, 5'd8, 32'd9, 32'd7, 32'd3, 5'd8, 1'b0, 32'h0};
        vecs[11] = '{2'b10, 6'h02, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'd0, 32'h80000000, 32'h7C2, 5'd1, 5'd2, 5'd12,
                     1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd1, 32'h80000000, 5'd12, 1'b0, 32'h1F08};
        vecs[12] = '{2'b10, 6'h27, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0F0F0F0F, 32'h00FF00FF, 32'h27, 5'd1, 5'd2, 5'd13,
                     1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'hF000F000, 32'h00FF00FF, 5'd13, 1'b0, 32'h9C};
        vecs[13] = '{2'b10, 6'h3F, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'd1, 32'd2, 32'h3F, 5'd1, 5'd2, 5'd14,
                     1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd3, 32'd2, 5'd14, 1'b0, 32'hFC};
        vecs[14] = '{2'b11, 6'h22, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h7FFFFFFF, 32'd1, 32'h0, 5'd1, 5'd2, 5'd0,
                     1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h80000000, 32'd1, 5'd2, 1'b0, 32'h0};
        vecs[15] = '{2'b10, 6'h24, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hF0F0, 32'hFF00, 32'h24, 5'd1, 5'd2, 5'd13,
                     1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'hF000, 32'hFF00, 5'd13, 1'b0, 32'h90};

        exp_q = '0;
        stall = 1'b0; flush = 1'b0;
        randomize_inputs();

        // Reset held two cycles with busy inputs.
        reset = 1'b1;
        cycle();
        cycle();
        check("reset_2cyc", '0);
        reset = 1'b0;
        apply_vec(vecs[0]);
        cycle();
        check("load_after_reset", {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'd12, 32'd7, 5'd9});
        reset = 1'b1; stall = 1'b1;
        cycle();
        check("reset_over_stall", '0);
        reset = 1'b0; stall = 1'b0;

        // Directed table.
        for (int i = 0; i < 16; i++) begin
            apply_vec(vecs[i]);
            cycle();
            check($sformatf("vec%0d", i),
                  {1'b0, 1'b1, 1'b0, vecs[i].memwrite, vecs[i].e_taken, vecs[i].e_target,
                   vecs[i].e_alu, vecs[i].e_store, vecs[i].e_wreg});
        end

        // Stall 3 cycles with changing inputs: outputs frozen at vec15 result.
        saved = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h90, 32'hF000, 32'hFF00, 5'd13};
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            cycle();
            check($sformatf("stall_hold%0d", i), saved);
        end
        stall = 1'b0;

        // Flush with live controls: bubble, but data still loads.
        apply_vec(vecs[0]);
        MemWrite = 1'b1; MemRead = 1'b1; MemToReg = 1'b1; Branch = 1'b1;
        flush = 1'b1;
        cycle();
        check_bit("flush_regwrite", RegWrite_out, 1'b0);
        check_bit("flush_memwrite", MemWrite_out, 1'b0);
        check("flush_bubble", {5'b0, 32'h80, 32'd12, 32'd7, 5'd9});

        // Flush and stall together: flush wins.
        read_data1 = 32'd20;
        stall = 1'b1;
        cycle();
        check("flush_over_stall", {5'b0, 32'h80, 32'd27, 32'd7, 5'd9});
        flush = 1'b0; stall = 1'b0;

        // Randomized cycles against the model.
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            reset = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 4) == 0);
            cycle();
            check($sformatf("rand%0d", i), exp_q);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
